spu32_cpu_div: RTL and testbench
================================

# spu32_cpu_div

Multi-cycle integer divider providing RV32M DIV/DIVU/REM/REMU for the spu32 core. It sits inside the ALU next to the multiplier and shares the multiplier's handshake: same operand, op and `O_busy` contract. The ALU ORs the divider's `O_busy` into its own busy output and selects `O_result` for the divide/remainder ops. The divider is radix-2 restoring, one quotient bit per clock, with special-case bypass for divide-by-zero and signed overflow.

## Interface
- No parameters.
- `I_clk`  in  1  clock; all state changes on the rising edge.
- `I_reset`  in  1  asynchronous, active-high reset.
- `I_en`  in  1  ALU enable; CPU holds it and all operands stable while `O_busy` is high.
- `I_op`  in  4  ALU opcode; only `ALUOP_DIV` and `ALUOP_REM` start a division.
- `I_op_signed`  in  2  signedness; 2'b11 = signed (DIV/REM); any other value = unsigned (DIVU/REMU).
- `I_s1`  in  32  dividend.
- `I_s2`  in  32  divisor.
- `O_result`  out  32  quotient (DIV) or remainder (REM); registered.
- `O_busy`  out  1  high while a division is pending; the CPU stalls on it.

## Operation
- States: IDLE, RUN, FIX, DONE.
- **IDLE**
  - `O_busy` = `I_en` && (`I_op` is DIV or REM), combinational, so the CPU stalls in the issue cycle.
  - On the edge where that term is high:
    - Divisor == 0: load `O_result` with 0xFFFFFFFF (DIV) or `I_s1` (REM), then go to DONE.
    - Signed, `I_s1`=0x80000000 and `I_s2`=0xFFFFFFFF: load 0x80000000 (DIV) or 0 (REM), then go to DONE.
    - Otherwise: latch |s1| and |s2| (magnitude only when signed), the sign flags, the op select and the op kind. Set `rem`=0 and `cnt`=31, then go to RUN.
- **RUN** (`O_busy`=1), one step per cycle:
  - `trial` = {`rem`[31:0], `quo`[31]} − {1'b0, `div`}, computed at 33 bits.
  - If no borrow: `rem` ← `trial`[31:0] and the new quotient LSB = 1. Otherwise `rem` ← the shifted value and the LSB = 0.
  - `quo` shifts left each step.
  - When `cnt`==0, go to FIX; otherwise `cnt` decrements.
  - `I_en`, `I_op` and operand changes are ignored because everything is latched.
- **FIX** (`O_busy`=1):
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Load `O_result` with the selected value, then go to DONE.
- **DONE**
  - `O_busy`=0 and `O_result` is valid.
  - Unconditionally go to IDLE on the next edge.
  - The CPU must drop `I_en`, or change the op, in the cycle after `O_busy` falls. Otherwise a new division starts.
- `O_result` holds its value until the next FIX or special-case load. Non-divide ops never change it.
- **Reset**
  - Asynchronous: state ← IDLE, `O_result` ← 0, internal registers ← 0.
  - `O_busy` is forced to 0 while `I_reset` is high.
  - Reset during RUN or FIX aborts the operation without completing it.

## Timing
- Normal division:
  - Issue cycle C0 (IDLE, busy=1), RUN C1–C32, FIX C33.
  - DONE in C34: busy=0 and the result is valid.
  - `O_busy` is high for 34 cycles.
- Special case: busy is high in C0 only. DONE is in C1 with the result valid.
- Back-to-back divisions: the earliest next issue is C35 (the IDLE after DONE).
- Only IDLE decodes `I_op`; RUN and FIX behaviour is fixed by the latched op.

## Structure
- Add `ALUOP_DIV` and `ALUOP_REM` to `aludefs.vh`. They use currently unused 4-bit codes, and the ALU result mux uses the same defines.
- State encoding is a local 2-bit `localparam` set.
- Single module with no sub-module. The 33-bit subtractor and the sign fix-up are inline.
- Instantiate in the ALU alongside the multiplier. `O_busy` to the ALU = mul busy | div busy.

## Test plan
- DIVU 100/7 → `O_busy` high for 34 cycles, then `O_result`=14. REMU on the same operands → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). REM 7 / 0xFFFFFFFE → 1.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0xFFFFFFF9/0 → 0xFFFFFFFF.
  - Busy for exactly 1 cycle.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. Busy for 1 cycle.
- Reset asserted mid-RUN (cycle 10):
  - `O_busy`=0 and `O_result`=0 immediately, without waiting for a clock edge.
  - After release, DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF in 34 cycles.
- `I_en` high with ADD/MUL ops → `O_busy` stays 0, `O_result` is unchanged, and the state stays IDLE. Change `I_s1` during RUN → the result is still computed from the latched operands.

Source files
------------

// File: rtl/spu32_cpu_div_pkg.sv
// spu32_cpu_div_pkg: ALU opcodes shared by the ALU result mux and the divider,
// plus the divider's FSM state type.
// No ports; imported with import spu32_cpu_div_pkg::*.
package spu32_cpu_div_pkg;

  // 4-bit ALU opcodes; DIV and REM occupy codes that were previously unused.
  localparam logic [3:0] ALUOP_ADD = 4'b0000;
  localparam logic [3:0] ALUOP_SUB = 4'b0001;
  localparam logic [3:0] ALUOP_MUL = 4'b1000;
  localparam logic [3:0] ALUOP_DIV = 4'b1001;
  localparam logic [3:0] ALUOP_REM = 4'b1010;

  // I_op_signed value that selects signed DIV/REM; anything else is unsigned.
  localparam logic [1:0] OP_SIGNED = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/spu32_cpu_div.sv
// spu32_cpu_div: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports: I_clk/I_reset (async active-high), I_en/I_op/I_op_signed/I_s1/I_s2
// from the ALU; O_result (registered quotient or remainder), O_busy (stall).
module spu32_cpu_div
  import spu32_cpu_div_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_en,
  input  logic [3:0]  I_op,
  input  logic [1:0]  I_op_signed,
  input  logic [31:0] I_s1,
  input  logic [31:0] I_s2,
  output logic [31:0] O_result,
  output logic        O_busy
);

  div_state_e  state_q, state_d;
  logic [31:0] result_q, result_d;
  logic [31:0] rem_q, rem_d;      // partial remainder
  logic [31:0] quo_q, quo_d;      // dividend shifting out, quotient shifting in
  logic [31:0] div_q, div_d;      // divisor magnitude
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;    // operand signs differ: negate quotient
  logic        rneg_q, rneg_d;    // dividend negative: negate remainder
  logic        is_rem_q, is_rem_d;

  logic        busy;
  logic        start;
  logic        op_rem;
  logic        op_signed;
  logic        s1_neg;
  logic        s2_neg;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        borrow;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign op_rem    = (I_op == ALUOP_REM);
  assign start     = I_en && ((I_op == ALUOP_DIV) || op_rem);
  assign op_signed = (I_op_signed == OP_SIGNED);
  assign s1_neg    = op_signed && I_s1[31];
  assign s2_neg    = op_signed && I_s2[31];

  // Shift in the next dividend bit and try subtracting the divisor. Because
  // rem < div always holds, a successful subtraction fits in 32 bits and
  // bit 32 of the 33-bit difference is a clean borrow flag.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, div_q};
  assign borrow  = trial[32];

  assign quo_fix = qneg_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix = rneg_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    is_rem_d = is_rem_q;
    busy     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Combinational busy so the CPU stalls in the issue cycle itself.
        busy = start;
        if (start) begin
          if (I_s2 == 32'd0) begin
            result_d = op_rem ? I_s1 : 32'hFFFF_FFFF;
            state_d  = ST_DONE;
          end else if (op_signed && (I_s1 == 32'h8000_0000) && (I_s2 == 32'hFFFF_FFFF)) begin
            result_d = op_rem ? 32'd0 : 32'h8000_0000;
            state_d  = ST_DONE;
          end else begin
            quo_d    = s1_neg ? (~I_s1 + 32'd1) : I_s1;
            div_d    = s2_neg ? (~I_s2 + 32'd1) : I_s2;
            qneg_d   = s1_neg ^ s2_neg;
            rneg_d   = s1_neg;
            is_rem_d = op_rem;
            rem_d    = 32'd0;
            cnt_d    = 5'd31;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        rem_d = borrow ? shifted[31:0] : trial[31:0];
        quo_d = {quo_q[30:0], ~borrow};
        if (cnt_q == 5'd0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_FIX: begin
        busy     = 1'b1;
        result_d = is_rem_q ? rem_fix : quo_fix;
        state_d  = ST_DONE;
      end
      default: begin
        // ST_DONE: result is valid this cycle, return to IDLE.
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q  <= ST_IDLE;
      result_q <= 32'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      div_q    <= 32'd0;
      cnt_q    <= 5'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      is_rem_q <= is_rem_d;
    end
  end

  assign O_result = result_q;
  assign O_busy   = busy && !I_reset;

endmodule

// File: tb/tb_spu32_cpu_div.sv
module tb_spu32_cpu_div;
  import spu32_cpu_div_pkg::*;

  logic        I_clk = 1'b0;
  logic        I_reset;
  logic        I_en;
  logic [3:0]  I_op;
  logic [1:0]  I_op_signed;
  logic [31:0] I_s1;
  logic [31:0] I_s2;
  logic [31:0] O_result;
  logic        O_busy;

  int total = 0;
  int bad   = 0;

  spu32_cpu_div dut (
    .I_clk       (I_clk),
    .I_reset     (I_reset),
    .I_en        (I_en),
    .I_op        (I_op),
    .I_op_signed (I_op_signed),
    .I_s1        (I_s1),
    .I_s2        (I_s2),
    .O_result    (O_result),
    .O_busy      (O_busy)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  sgn;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] exp_res;
    int          exp_busy;
  } vec_t;

  vec_t vecs[16];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues an op at a negedge and counts cycles (sampled 1ns after each
  // negedge) while busy is high. Returns with en dropped during DONE.
  task automatic run_op(input logic [3:0] op, input logic [1:0] sgn,
                        input logic [31:0] s1, input logic [31:0] s2,
                        output int cycles);
    @(negedge I_clk);
    I_en = 1'b1; I_op = op; I_op_signed = sgn; I_s1 = s1; I_s2 = s2;
    cycles = 0;
    #1;
    while (O_busy && cycles < 100) begin
      cycles++;
      @(negedge I_clk);
      #1;
    end
    I_en = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [31:0] held;

    // {op, signedness, s1, s2, expected result, expected busy cycles}
    vecs[0]  = '{ALUOP_DIV, 2'b00, 32'd100,        32'd7,          32'd14,         34};
    vecs[1]  = '{ALUOP_REM, 2'b00, 32'd100,        32'd7,          32'd2,          34};
    vecs[2]  = '{ALUOP_DIV, 2'b11, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vecs[3]  = '{ALUOP_REM, 2'b11, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[4]  = '{ALUOP_REM, 2'b11, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
    vecs[5]  = '{ALUOP_DIV, 2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[6]  = '{ALUOP_REM, 2'b00, 32'd5,          32'd0,          32'd5,          1};
    vecs[7]  = '{ALUOP_DIV, 2'b11, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1};
    vecs[8]  = '{ALUOP_DIV, 2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[9]  = '{ALUOP_REM, 2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[10] = '{ALUOP_DIV, 2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
    vecs[11] = '{ALUOP_REM, 2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
    vecs[12] = '{ALUOP_DIV, 2'b11, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34};
    vecs[13] = '{ALUOP_REM, 2'b11, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34};
    vecs[14] = '{ALUOP_DIV, 2'b01, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  34};
    vecs[15] = '{ALUOP_REM, 2'b11, 32'd6,          32'd3,          32'd0,          34};

    I_reset = 1'b1; I_en = 1'b0; I_op = ALUOP_ADD; I_op_signed = 2'b00;
    I_s1 = 32'd0; I_s2 = 32'd0;
    repeat (3) @(posedge I_clk);
    #1;
    check32("reset_result", O_result, 32'd0);
    check32("reset_busy", {31'd0, O_busy}, 32'd0);
    @(negedge I_clk);
    I_reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].sgn, vecs[i].s1, vecs[i].s2, cyc);
      check_int($sformatf("vec%0d_busy_cycles", i), cyc, vecs[i].exp_busy);
      check32($sformatf("vec%0d_result", i), O_result, vecs[i].exp_res);
    end

    // Non-divide ops with en high: no busy, result untouched, still IDLE.
    held = O_result;
    @(negedge I_clk);
    I_en = 1'b1; I_op = ALUOP_ADD; I_s1 = 32'd9; I_s2 = 32'd0;
    #1;
    check32("add_busy", {31'd0, O_busy}, 32'd0);
    @(negedge I_clk);
    I_op = ALUOP_MUL;
    #1;
    check32("mul_busy", {31'd0, O_busy}, 32'd0);
    repeat (3) @(negedge I_clk);
    check32("nondiv_result_held", O_result, held);
    I_en = 1'b0;
    run_op(ALUOP_DIV, 2'b00, 32'd50, 32'd5, cyc);
    check_int("after_nondiv_busy_cycles", cyc, 34);
    check32("after_nondiv_result", O_result, 32'd10);

    // Operands change during RUN: latched values must be used.
    @(negedge I_clk);
    I_en = 1'b1; I_op = ALUOP_DIV; I_op_signed = 2'b00; I_s1 = 32'd100; I_s2 = 32'd7;
    cyc = 0;
    #1;
    while (O_busy && cyc < 100) begin
      cyc++;
      if (cyc == 5) begin
        I_s1 = 32'd1000; I_s2 = 32'd3; I_op = ALUOP_REM; I_op_signed = 2'b11;
      end
      @(negedge I_clk);
      #1;
    end
    I_en = 1'b0;
    check_int("latched_busy_cycles", cyc, 34);
    check32("latched_result", O_result, 32'd14);

    // Reset asserted at cycle 10 of a long division.
    @(negedge I_clk);
    I_en = 1'b1; I_op = ALUOP_DIV; I_op_signed = 2'b00; I_s1 = 32'd100; I_s2 = 32'd7;
    repeat (10) @(negedge I_clk);
    #1;
    check32("pre_reset_busy", {31'd0, O_busy}, 32'd1);
    I_reset = 1'b1;
    #1;
    check32("midrun_reset_busy", {31'd0, O_busy}, 32'd0);
    check32("midrun_reset_result", O_result, 32'd0);
    I_en = 1'b0;
    @(negedge I_clk);
    I_reset = 1'b0;
    run_op(ALUOP_DIV, 2'b00, 32'hFFFF_FFFF, 32'd1, cyc);
    check_int("post_reset_busy_cycles", cyc, 34);
    check32("post_reset_result", O_result, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
